tepc_pulse_peak: RTL and testbench

- Upstream stage of the histogram block. Captures the TEPC ADC sample stream (12-bit data, OR, DCO) into the 100 MHz clk domain.
- Detects threshold-crossing pulses and tracks each pulse's maximum amplitude.
- Presents one peak value per pulse to the histogram through a valid/ready handshake.
- Discards pile-up (over-long) pulses and events that arrive while the output is stalled, and counts every discarded event.

---
 rtl/tepc_pulse_peak.sv | 181 ++++++++++++++++++
 tb/tb_tepc_pulse_peak.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tepc_pulse_peak.sv
// rtl/tepc_pulse_peak.sv - TEPC ADC capture, pulse peak detection and one-deep peak output
// Optional feature macro: TEPC_OR_CLAMP_EN (out-of-range pulses report 12'hFFF instead of being dropped)
module tepc_pulse_peak #(
  parameter logic [11:0] THRESHOLD = 12'd100,
  parameter logic [11:0] HYST      = 12'd10,
  parameter int          HOLDOFF   = 8,
  parameter int          MAX_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] TEPC_ADC,
  input  logic        OR,
  input  logic        DCO,
  output logic        peak_valid,
  output logic [11:0] peak_data,
  input  logic        peak_ready,
  output logic [15:0] drop_count,
  output logic        busy
);

  // Pulse end level, clamped so a large hysteresis cannot wrap around.
  localparam logic [11:0] END_LEVEL = (THRESHOLD > HYST) ? (THRESHOLD - HYST) : 12'd0;
  localparam int          WW        = $clog2(MAX_WIDTH + 1);
  localparam int          HW        = $clog2(HOLDOFF + 1);
  localparam logic [WW-1:0] MAX_W     = WW'(MAX_WIDTH);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

  typedef enum logic [1:0] {IDLE, PEAK, HOLD} state_t;

  // Capture path registers
  logic        d1, d2, d3;
  logic [11:0] adc_r1, adc_r2;
  logic        or_r1, or_r2;
  logic        filled, armed;
  logic        strobe;
  logic [11:0] sample;
  logic        sample_or;

  // FSM registers and next-state values
  state_t      state, state_n;
  logic [11:0] max_r, max_n;
  logic [WW-1:0] width, width_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic        or_seen, or_seen_n;
  logic        emit, discard;
  logic [11:0] emit_data;

  logic        load, drop_inc;

  // Synchronize DCO and delay the sample bus by the same two stages so the
  // data seen on a strobe is the value registered when DCO was first seen high.
  // armed blocks a spurious strobe when DCO is already high as reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1     <= 1'b0;
      d2     <= 1'b0;
      d3     <= 1'b0;
      adc_r1 <= 12'd0;
      adc_r2 <= 12'd0;
      or_r1  <= 1'b0;
      or_r2  <= 1'b0;
      filled <= 1'b0;
      armed  <= 1'b0;
    end else begin
      d1     <= DCO;
      d2     <= d1;
      d3     <= d2;
      adc_r1 <= TEPC_ADC;
      adc_r2 <= adc_r1;
      or_r1  <= OR;
      or_r2  <= or_r1;
      filled <= 1'b1;
      armed  <= armed | (filled & ~d1);
    end
  end

  assign strobe    = d2 & ~d3 & armed;
  assign sample    = adc_r2;
  assign sample_or = or_r2;

  // FSM and pulse-tracking state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      max_r   <= 12'd0;
      width   <= '0;
      hcnt    <= '0;
      or_seen <= 1'b0;
    end else begin
      state   <= state_n;
      max_r   <= max_n;
      width   <= width_n;
      hcnt    <= hcnt_n;
      or_seen <= or_seen_n;
    end
  end

  // Next-state logic; everything holds except on strobe cycles.
  always_comb begin
    state_n   = state;
    max_n     = max_r;
    width_n   = width;
    hcnt_n    = hcnt;
    or_seen_n = or_seen;
    emit      = 1'b0;
    discard   = 1'b0;
    emit_data = max_r;
    if (strobe) begin
      case (state)
        IDLE: begin
          if (sample >= THRESHOLD) begin
            state_n   = PEAK;
            max_n     = sample;
            or_seen_n = sample_or;
            width_n   = WW'(1);
          end
        end
        PEAK: begin
          if (sample < END_LEVEL) begin
            // The ending sample is below the pulse and contributes nothing.
            state_n = HOLD;
            hcnt_n  = HOLD_LOAD;
`ifdef TEPC_OR_CLAMP_EN
            emit      = 1'b1;
            emit_data = or_seen ? 12'hFFF : max_r;
`else
            if (or_seen) begin
              discard = 1'b1;
            end else begin
              emit = 1'b1;
            end
`endif
          end else begin
            max_n     = (sample > max_r) ? sample : max_r;
            or_seen_n = or_seen | sample_or;
            width_n   = width + WW'(1);
            if (width_n == MAX_W) begin
              discard = 1'b1;
              state_n = HOLD;
              hcnt_n  = HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          hcnt_n = hcnt - HW'(1);
          if (hcnt_n == '0) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign load     = emit & (~peak_valid | peak_ready);
  assign drop_inc = discard | (emit & ~load);

  // One-deep output register and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_valid <= 1'b0;
      peak_data  <= 12'd0;
      drop_count <= 16'd0;
    end else begin
      if (load) begin
        peak_valid <= 1'b1;
        peak_data  <= emit_data;
      end else if (peak_valid && peak_ready) begin
        peak_valid <= 1'b0;
      end
      if (drop_inc && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tepc_pulse_peak.sv
// tb/tb_tepc_pulse_peak.sv - directed self-checking bench for tepc_pulse_peak
module tb_tepc_pulse_peak;

  logic        clk;
  logic        rst;
  logic [11:0] TEPC_ADC;
  logic        OR;
  logic        DCO;
  logic        peak_valid;
  logic [11:0] peak_data;
  logic        peak_ready;
  logic [15:0] drop_count;
  logic        busy;

  int n_checks;
  int n_fail;
  int xfer_cnt;
  logic [11:0] last_data;

  tepc_pulse_peak dut (
    .clk        (clk),
    .rst        (rst),
    .TEPC_ADC   (TEPC_ADC),
    .OR         (OR),
    .DCO        (DCO),
    .peak_valid (peak_valid),
    .peak_data  (peak_data),
    .peak_ready (peak_ready),
    .drop_count (drop_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every handshake transfer (valid & ready at negedge -> transfer at next posedge).
  initial begin
    xfer_cnt  = 0;
    last_data = 12'd0;
  end
  always @(negedge clk) begin
    if (peak_valid && peak_ready) begin
      xfer_cnt  = xfer_cnt + 1;
      last_data = peak_data;
    end
  end

  // One ADC sample with DCO at 25 MHz: 2 clk high, 2 clk low.
  task automatic send(input logic [11:0] v, input logic o);
    @(posedge clk);
    #2;
    TEPC_ADC = v;
    OR       = o;
    DCO      = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    DCO = 1'b0;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(12'd50, 1'b0);
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    DCO        = 1'b0;
    TEPC_ADC   = 12'd0;
    OR         = 1'b0;
    peak_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0d expected 0", peak_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0d expected 0", busy); end
    n_checks++;
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop got %0d expected 0", drop_count); end
    n_checks++;
    if (peak_data !== 12'd0) begin n_fail++; $display("FAIL reset_data got %0d expected 0", peak_data); end
    idle(4);
    @(negedge clk);
    n_checks++;
    if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %0d expected 0", peak_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %0d expected 0", busy); end
    n_checks++;
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL idle_drop got %0d expected 0", drop_count); end
  endtask

  task automatic test_single;
    int base;
    base = xfer_cnt;
    peak_ready = 1'b1;
    send(12'd50, 1'b0);
    send(12'd120, 1'b0);
    send(12'd300, 1'b0);
    send(12'd250, 1'b0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %0d expected 1", busy); end
    // Ending sample 80: DCO rises just after edge e0; valid must rise at the third edge.
    @(posedge clk);
    #2;
    TEPC_ADC = 12'd80;
    DCO      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %0d expected 0", peak_valid); end
    @(posedge clk);
    #1;
    n_checks++;
    if (peak_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_edge got %0d expected 1", peak_valid); end
    n_checks++;
    if (peak_data !== 12'd300) begin n_fail++; $display("FAIL single_data got %0d expected 300", peak_data); end
    DCO = 1'b0;
    repeat (2) @(posedge clk);
    idle(9);
    @(negedge clk);
    n_checks++;
    if (xfer_cnt - base !== 1) begin n_fail++; $display("FAIL single_xfers got %0d expected 1", xfer_cnt - base); end
    n_checks++;
    if (last_data !== 12'd300) begin n_fail++; $display("FAIL single_xfer_data got %0d expected 300", last_data); end
    n_checks++;
    if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after got %0d expected 0", peak_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got %0d expected 0", busy); end
  endtask

  task automatic test_hysteresis;
    int base;
    base = xfer_cnt;
    send(12'd150, 1'b0);
    send(12'd95, 1'b0);
    send(12'd200, 1'b0);
    send(12'd85, 1'b0);
    idle(9);
    @(negedge clk);
    n_checks++;
    if (xfer_cnt - base !== 1) begin n_fail++; $display("FAIL hyst_xfers got %0d expected 1", xfer_cnt - base); end
    n_checks++;
    if (last_data !== 12'd200) begin n_fail++; $display("FAIL hyst_data got %0d expected 200", last_data); end
    n_checks++;
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL hyst_drop got %0d expected 0", drop_count); end
  endtask

  task automatic test_back_pressure;
    int base;
    base = xfer_cnt;
    peak_ready = 1'b0;
    send(12'd400, 1'b0);
    send(12'd40, 1'b0);
    idle(9);
    send(12'd500, 1'b0);
    send(12'd40, 1'b0);
    idle(9);
    @(negedge clk);
    n_checks++;
    if (peak_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %0d expected 1", peak_valid); end
    n_checks++;
    if (peak_data !== 12'd400) begin n_fail++; $display("FAIL bp_data got %0d expected 400", peak_data); end
    n_checks++;
    if (drop_count !== 16'd1) begin n_fail++; $display("FAIL bp_drop got %0d expected 1", drop_count); end
    @(posedge clk);
    #2 peak_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (xfer_cnt - base !== 1) begin n_fail++; $display("FAIL bp_xfers got %0d expected 1", xfer_cnt - base); end
    n_checks++;
    if (last_data !== 12'd400) begin n_fail++; $display("FAIL bp_xfer_data got %0d expected 400", last_data); end
    n_checks++;
    if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after got %0d expected 0", peak_valid); end
  endtask

  task automatic test_pileup;
    int base;
    base = xfer_cnt;
    for (int i = 0; i < 64; i++) send(12'd200, 1'b0);
    @(negedge clk);
    n_checks++;
    if (drop_count !== 16'd2) begin n_fail++; $display("FAIL pile_drop got %0d expected 2", drop_count); end
    n_checks++;
    if (xfer_cnt - base !== 0) begin n_fail++; $display("FAIL pile_xfers got %0d expected 0", xfer_cnt - base); end
    // Holdoff samples 1..8 ignored (8th is a tall 350); sample 9 starts the reported pulse.
    send(12'd250, 1'b0);
    send(12'd40, 1'b0);
    for (int i = 0; i < 5; i++) send(12'd50, 1'b0);
    send(12'd350, 1'b0);
    send(12'd300, 1'b0);
    send(12'd40, 1'b0);
    idle(9);
    @(negedge clk);
    n_checks++;
    if (xfer_cnt - base !== 1) begin n_fail++; $display("FAIL hold_xfers got %0d expected 1", xfer_cnt - base); end
    n_checks++;
    if (last_data !== 12'd300) begin n_fail++; $display("FAIL hold_data got %0d expected 300", last_data); end
    n_checks++;
    if (drop_count !== 16'd2) begin n_fail++; $display("FAIL hold_drop got %0d expected 2", drop_count); end
  endtask

  task automatic test_or;
    int base;
    base = xfer_cnt;
    send(12'd150, 1'b0);
    send(12'd4095, 1'b1);
    send(12'd40, 1'b0);
    idle(9);
    @(negedge clk);
`ifdef TEPC_OR_CLAMP_EN
    n_checks++;
    if (xfer_cnt - base !== 1) begin n_fail++; $display("FAIL or_xfers got %0d expected 1", xfer_cnt - base); end
    n_checks++;
    if (last_data !== 12'hFFF) begin n_fail++; $display("FAIL or_data got %0d expected 4095", last_data); end
    n_checks++;
    if (drop_count !== 16'd2) begin n_fail++; $display("FAIL or_drop got %0d expected 2", drop_count); end
`else
    n_checks++;
    if (xfer_cnt - base !== 0) begin n_fail++; $display("FAIL or_xfers got %0d expected 0", xfer_cnt - base); end
    n_checks++;
    if (drop_count !== 16'd3) begin n_fail++; $display("FAIL or_drop got %0d expected 3", drop_count); end
`endif
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL or_busy got %0d expected 0", busy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_hysteresis();
    test_back_pressure();
    test_pileup();
    test_or();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
